// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder for Breakout controls: tracks E0/F0/E1 prefixes
// and turns make/break sequences into paddle holds, launch and level selection.
module ps2_key_decoder #(
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter int         CNT_W          = 17,
  parameter logic [3:0] DEFAULT_LEVEL  = 4'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       byte_err,
  output logic       left_held,
  output logic       right_held,
  output logic       launch_pulse,
  output logic [3:0] level,
  output logic       level_valid,
  output logic [7:0] err_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BRK     = 3'd1,
    S_EXT     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_SKIP    = 3'd4
  } state_t;

  localparam logic [7:0] C_EXT   = 8'hE0;
  localparam logic [7:0] C_BRK   = 8'hF0;
  localparam logic [7:0] C_PAUSE = 8'hE1;
  localparam logic [7:0] C_SPACE = 8'h29;
  localparam logic [7:0] C_LEFT  = 8'h6B;
  localparam logic [7:0] C_RIGHT = 8'h74;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Digit keys 1..8 map to levels 1..8; zero means "not a level key".
  function automatic logic [3:0] digit_level(input logic [7:0] code);
    logic [3:0] lvl;
    case (code)
      8'h16:   lvl = 4'd1;
      8'h1E:   lvl = 4'd2;
      8'h26:   lvl = 4'd3;
      8'h25:   lvl = 4'd4;
      8'h2E:   lvl = 4'd5;
      8'h36:   lvl = 4'd6;
      8'h3D:   lvl = 4'd7;
      8'h3E:   lvl = 4'd8;
      default: lvl = 4'd0;
    endcase
    return lvl;
  endfunction

  state_t           r_state;
  logic [2:0]       r_skip_cnt;
  logic [CNT_W-1:0] r_to_cnt;
  logic             r_space_held;
  logic             r_left_held;
  logic             r_right_held;
  logic             r_launch_pulse;
  logic [3:0]       r_level;
  logic             r_level_valid;
  logic [7:0]       r_err_count;
  logic [3:0]       w_digit;

  assign w_digit = digit_level(byte_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_skip_cnt     <= 3'd0;
      r_to_cnt       <= '0;
      r_space_held   <= 1'b0;
      r_left_held    <= 1'b0;
      r_right_held   <= 1'b0;
      r_launch_pulse <= 1'b0;
      r_level        <= DEFAULT_LEVEL;
      r_level_valid  <= 1'b0;
      r_err_count    <= 8'd0;
    end else begin
      r_launch_pulse <= 1'b0;
      r_level_valid  <= 1'b0;
      if (byte_valid) begin
        r_to_cnt <= '0;
        if (byte_err) begin
          r_state      <= S_IDLE;
          r_left_held  <= 1'b0;
          r_right_held <= 1'b0;
          r_space_held <= 1'b0;
          if (r_err_count != 8'hFF) begin
            r_err_count <= r_err_count + 8'd1;
          end
        end else if (r_state == S_SKIP) begin
          // Pause emits a fixed 8-byte burst with no break code; swallow it whole.
          r_skip_cnt <= r_skip_cnt - 3'd1;
          if (r_skip_cnt <= 3'd1) begin
            r_state <= S_IDLE;
          end
        end else if (byte_in == C_EXT) begin
          r_state <= S_EXT;
        end else if (byte_in == C_BRK) begin
          case (r_state)
            S_IDLE:  r_state <= S_BRK;
            S_EXT:   r_state <= S_EXT_BRK;
            default: r_state <= r_state;
          endcase
        end else if (byte_in == C_PAUSE) begin
          r_state    <= S_SKIP;
          r_skip_cnt <= 3'd7;
        end else begin
          r_state <= S_IDLE;
          case (r_state)
            S_IDLE: begin
              if (byte_in == C_SPACE) begin
                r_launch_pulse <= ~r_space_held;
                r_space_held   <= 1'b1;
              end
            end
            S_BRK: begin
              if (byte_in == C_SPACE) begin
                r_space_held <= 1'b0;
              end else if (w_digit != 4'd0) begin
                r_level       <= w_digit;
                r_level_valid <= 1'b1;
              end
            end
            S_EXT: begin
              if (byte_in == C_LEFT) begin
                r_left_held <= 1'b1;
              end else if (byte_in == C_RIGHT) begin
                r_right_held <= 1'b1;
              end
            end
            S_EXT_BRK: begin
              if (byte_in == C_LEFT) begin
                r_left_held <= 1'b0;
              end else if (byte_in == C_RIGHT) begin
                r_right_held <= 1'b0;
              end
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end else if (r_state != S_IDLE) begin
        // Abandon a half-received sequence; held flags survive the timeout.
        if (r_to_cnt == TO_LAST) begin
          r_state  <= S_IDLE;
          r_to_cnt <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + CNT_W'(1);
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign left_held    = r_left_held;
  assign right_held   = r_right_held;
  assign launch_pulse = r_launch_pulse;
  assign level        = r_level;
  assign level_valid  = r_level_valid;
  assign err_count    = r_err_count;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios followed by
// random byte streams, all compared every cycle against a prefix-flag model.
module tb_ps2_key_decoder;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_err;
  logic       left_held, right_held, launch_pulse, level_valid;
  logic [3:0] level;
  logic [7:0] err_count;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .CNT_W(5), .DEFAULT_LEVEL(4'd1)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_err(byte_err), .left_held(left_held), .right_held(right_held),
    .launch_pulse(launch_pulse), .level(level), .level_valid(level_valid),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int launch_seen = 0;

  // Reference model: pending-prefix flags, bytes left to skip, idle wait.
  bit   m_ext, m_brk, m_space;
  int   m_skip, m_wait;
  logic exp_left, exp_right, exp_launch, exp_lv;
  logic [3:0] exp_level;
  int   exp_err;
  logic [7:0] digit_codes [8] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_space = 0; m_skip = 0; m_wait = 0;
    exp_left = 0; exp_right = 0; exp_launch = 0; exp_lv = 0;
    exp_level = 4'd1; exp_err = 0;
  endtask

  task automatic model_step(input bit v, input bit e, input logic [7:0] b, input bit r);
    if (r) begin
      model_reset();
      return;
    end
    exp_launch = 0;
    exp_lv = 0;
    if (v) begin
      m_wait = 0;
      if (e) begin
        m_ext = 0; m_brk = 0; m_skip = 0;
        exp_left = 0; exp_right = 0; m_space = 0;
        if (exp_err < 255) exp_err++;
      end else if (m_skip > 0) begin
        m_skip--;
      end else if (b == 8'hE0) begin
        m_ext = 1; m_brk = 0;
      end else if (b == 8'hF0) begin
        m_brk = 1;
      end else if (b == 8'hE1) begin
        m_ext = 0; m_brk = 0; m_skip = 7;
      end else begin
        if (m_ext && !m_brk) begin
          if (b == 8'h6B) exp_left = 1;
          if (b == 8'h74) exp_right = 1;
        end else if (m_ext && m_brk) begin
          if (b == 8'h6B) exp_left = 0;
          if (b == 8'h74) exp_right = 0;
        end else if (m_brk) begin
          if (b == 8'h29) m_space = 0;
          for (int i = 0; i < 8; i++) begin
            if (b == digit_codes[i]) begin
              exp_level = 4'(i + 1);
              exp_lv = 1;
            end
          end
        end else if (b == 8'h29) begin
          exp_launch = !m_space;
          m_space = 1;
        end
        m_ext = 0; m_brk = 0;
      end
    end else if (m_ext || m_brk || m_skip > 0) begin
      if (m_wait == TO - 1) begin
        m_ext = 0; m_brk = 0; m_skip = 0; m_wait = 0;
      end else begin
        m_wait++;
      end
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic tick(input bit v, input bit e, input logic [7:0] b, input bit r);
    rst = r; byte_valid = v; byte_err = e; byte_in = b;
    @(posedge clk);
    model_step(v, e, b, r);
    #1;
    if (launch_pulse === 1'b1) launch_seen++;
    check_eq("left_held",    left_held,    exp_left);
    check_eq("right_held",   right_held,   exp_right);
    check_eq("launch_pulse", launch_pulse, exp_launch);
    check_eq("level",        level,        exp_level);
    check_eq("level_valid",  level_valid,  exp_lv);
    check_eq("err_count",    err_count,    exp_err);
  endtask

  task automatic send(input logic [7:0] b);
    tick(1, 0, b, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 8'h00, 0);
  endtask

  logic [7:0] pool [16] = '{8'hE0, 8'hF0, 8'hE1, 8'h29, 8'h6B, 8'h74, 8'h16, 8'h1E,
                            8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'hAA, 8'h14};
  logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  initial begin
    model_reset();
    rst = 1; byte_valid = 0; byte_err = 0; byte_in = 8'h00;
    #1;
    tick(0, 0, 8'h00, 1);
    tick(0, 0, 8'h00, 1);
    check_eq("rst_level", level, 4'd1);
    check_eq("rst_err", err_count, 8'd0);

    // Space: typematic repeats suppressed, release re-arms launch.
    launch_seen = 0;
    send(8'h29); idle(1); send(8'h29); idle(2); send(8'h29); idle(1);
    send(8'hF0); idle(1); send(8'h29); idle(1); send(8'h29); idle(1);
    check_eq("launch_count", launch_seen, 2);
    send(8'h29); idle(1);
    check_eq("launch_count_held", launch_seen, 2);
    check_eq("space_level", level, 4'd1);

    // Arrows.
    send(8'hE0); send(8'h6B);
    check_eq("left_make", left_held, 1'b1);
    send(8'hE0); send(8'h74);
    check_eq("right_make", right_held, 1'b1);
    check_eq("both_held", left_held, 1'b1);
    send(8'hE0); send(8'hF0); send(8'h6B);
    check_eq("left_break", left_held, 1'b0);
    check_eq("right_still", right_held, 1'b1);
    send(8'h6B); idle(2);
    check_eq("keypad_left", left_held, 1'b0);

    // Level selection on release only.
    send(8'hF0); send(8'h26);
    check_eq("lv3_pulse", level_valid, 1'b1);
    check_eq("lv3", level, 4'd3);
    idle(1);
    check_eq("lv_pulse_end", level_valid, 1'b0);
    send(8'h26); idle(1);
    check_eq("digit_make", level, 4'd3);
    send(8'hF0); send(8'h3E);
    check_eq("lv8", level, 4'd8);

    // Timeout: expired prefix, then byte coinciding with expiry.
    send(8'hE0); idle(TO); send(8'h6B);
    check_eq("to_expired", left_held, 1'b0);
    send(8'hE0); idle(TO - 1); send(8'h6B);
    check_eq("to_coincide", left_held, 1'b1);
    send(8'hE0); send(8'hF0); idle(5); send(8'h6B);
    check_eq("to_partial", left_held, 1'b0);

    // Pause sequence is swallowed, next release works.
    for (int i = 0; i < 8; i++) send(pause_seq[i]);
    check_eq("pause_level", level, 4'd8);
    send(8'hF0); send(8'h16);
    check_eq("post_pause_lv", level, 4'd1);
    check_eq("post_pause_pulse", level_valid, 1'b1);

    // Errors clear holds and saturate the counter.
    send(8'hE0); send(8'h6B);
    tick(0, 1, 8'h55, 0);
    check_eq("err_no_valid", err_count, 8'd0);
    tick(1, 1, 8'h55, 0);
    check_eq("err_left", left_held, 1'b0);
    check_eq("err_right", right_held, 1'b0);
    check_eq("err_one", err_count, 8'd1);
    for (int i = 0; i < 300; i++) tick(1, 1, 8'(i), 0);
    check_eq("err_sat", err_count, 8'd255);

    // Reset wins over a coincident byte.
    send(8'hE0); send(8'h74); send(8'hE0); send(8'hF0);
    tick(1, 0, 8'h74, 1);
    check_eq("rst_mid_right", right_held, 1'b0);
    check_eq("rst_mid_err", err_count, 8'd0);
    send(8'h74);
    check_eq("rst_byte_lost", right_held, 1'b0);

    // Random streams against the model.
    for (int n = 0; n < 4000; n++) begin
      int roll;
      roll = $urandom_range(0, 999);
      if (roll < 8) begin
        tick($urandom_range(0, 1), 0, pool[$urandom_range(0, 15)], 1);
      end else if (roll < 40) begin
        idle($urandom_range(TO - 3, TO + 3));
      end else if (roll < 70) begin
        tick(1, 1, 8'($urandom), 0);
      end else if (roll < 550) begin
        tick(1, 0, pool[$urandom_range(0, 15)], 0);
      end else begin
        tick(0, $urandom_range(0, 1), 8'($urandom), 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Downstream of the PS/2 byte receiver. Consumes one validated scan-code byte at a time (set 2) and turns make/break sequences into game controls for Breakout.
- Controls produced: left/right paddle hold flags, a launch pulse, and level selection (digits 1-8 on release).
- Replaces ad-hoc byte-pair matching with a prefix-tracking FSM that handles E0/F0/E1 and recovers from lost bytes.

Parameters:
- TIMEOUT_CYCLES, 100000: idle clocks after which a half-received prefix sequence is abandoned (1 ms at 100 MHz).
- CNT_W, 17: width of the timeout counter; must hold TIMEOUT_CYCLES.
- DEFAULT_LEVEL, 1: level value after reset (range 1-8).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- byte_in  in  8  received scan-code byte, valid only when byte_valid=1.
- byte_valid  in  1  one-cycle strobe per received byte; may be asserted on consecutive cycles.
- byte_err  in  1  parity/framing error for the byte qualified by byte_valid.
- left_held  out  1  high while extended Left arrow (E0 6B) is held.
- right_held  out  1  high while extended Right arrow (E0 74) is held.
- launch_pulse  out  1  one-cycle pulse on a fresh Space make (29).
- level  out  4  current selected level, 1-8.
- level_valid  out  1  one-cycle pulse when level is written.
- err_count  out  8  saturating count of bytes flagged byte_err.

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-high.
- Reset values: state=IDLE, left_held=0, right_held=0, space_held(internal)=0, launch_pulse=0, level=DEFAULT_LEVEL, level_valid=0, err_count=0, timeout counter=0, skip counter=0.
- Latency: all outputs are registered. A byte accepted in cycle N changes its outputs at the edge ending cycle N. Pulses last exactly one cycle.
- FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0), SKIP (Pause sequence).
- Transitions on byte_valid=1 with byte_err=0:
  - E0 in any state except SKIP -> EXT.
  - F0: from IDLE -> BRK; from EXT -> EXT_BRK; from BRK or EXT_BRK, stay in the current state.
  - E1 from IDLE, BRK, EXT or EXT_BRK -> SKIP, with the skip counter loaded to 7.
  - In SKIP, every byte (including E0/F0) decrements the skip counter. At 0 -> IDLE. No action is taken.
  - Any other byte: execute the action for the current state, then -> IDLE.
- Actions:
  - IDLE + 29: if space_held=0, pulse launch_pulse. Set space_held=1. Typematic repeats of 29 therefore do not re-pulse.
  - BRK + 29: space_held=0.
  - EXT + 6B: left_held=1. EXT_BRK + 6B: left_held=0.
  - EXT + 74: right_held=1. EXT_BRK + 74: right_held=0.
  - BRK + 16/1E/26/25/2E/36/3D/3E: level=1..8 respectively, and pulse level_valid. Writing the same value still pulses.
  - All other codes are ignored. This includes non-extended 6B/74 (keypad), digit makes, AA, FA and EE.
- Both arrows held: left_held and right_held are both 1. The paddle logic resolves the conflict.
- byte_err=1 with byte_valid=1:
  - Discard the byte and go to IDLE.
  - Clear left_held, right_held and space_held. No pulses are issued.
  - Increment err_count, saturating at 255.
- byte_err with byte_valid=0 is ignored.
- Timeout:
  - The counter clears on every byte_valid and counts while state != IDLE.
  - When it reaches TIMEOUT_CYCLES-1 -> IDLE, counter=0. Held flags are unchanged.
  - If byte_valid coincides with expiry, the byte is processed in the current (pre-timeout) state.
- Reset mid-sequence: rst wins over byte_valid in the same cycle. The byte is lost.
- level never takes values outside 1-8.

Test Plan:
- Reset, then bytes 29, 29, 29, F0 29, 29 on non-consecutive cycles -> launch_pulse exactly twice (first 29 and last 29). space_held ends at 1. level=1, err_count=0.
- E0 6B, E0 74, E0 F0 6B -> left_held 1 then 0. right_held 1 throughout. Non-extended 6B alone leaves left_held 0.
- F0 26 -> level=3 with a one-cycle level_valid. Then 26 (make) -> no change. Then back-to-back strobes F0,3E -> level=8.
- E0 then no byte for TIMEOUT_CYCLES (set to 20 in the bench) -> state IDLE by cycle 20. A following 6B leaves left_held 0. Repeat with byte_valid arriving on the expiry cycle -> the byte is treated as extended.
- Sequence E1 14 77 E1 F0 14 F0 77 (Pause), then F0 16 -> no actions during Pause. level=1 pulses after the sequence.
- Hold E0 6B, then a byte with byte_err=1 -> left_held=0, err_count=1. Then 300 error bytes -> err_count saturates at 255. rst asserted mid E0 F0 -> all outputs return to reset values next cycle.
